sensor_level_filter: RTL
========================

// Module: sensor_level_filter
// PURPOSE
//  Conditions the raw liquid-level probe inputs before the threshold/display stage. Synchronises the
//  8 probe lines, debounces them as one vector, and checks that wetted probes form a contiguous
//  column from bit 0 (bottom) upward. Publishes a settled level 0..8 with a change strobe and a
//  sensor-fault flag, consumed by the threshold compare (saveH/saveL), LED and 7-seg logic.
// PARAMETERS
//  N_SENSORS      8        probe count; bit 0 = lowest probe
//  STABLE_CYCLES  500_000  clocks the synchronised vector must hold unchanged before commit (5 ms @100 MHz)
//  LEVEL_W        4        width of level output; must satisfy 2**LEVEL_W > N_SENSORS
// PORTS
//  clk_100MHz     in   1          system clock, 100 MHz, all logic on rising edge
//  reset_n        in   1          asynchronous, active-low reset
//  sensors_input  in   N_SENSORS  raw asynchronous probe lines, 1 = probe wetted
//  stable_bits    out  N_SENSORS  last committed debounced probe vector
//  level          out  LEVEL_W    committed level = count of contiguous 1s from bit 0
//  level_valid    out  1          one-cycle strobe when stable_bits changes on a commit
//  sensor_fault   out  1          committed vector is not a thermometer code (1s above a 0)
// BEHAVIOUR
//  Reset (async assert, sync-released by the clock domain): sync stages, candidate, counter = 0;
//   stable_bits=0, level=0, level_valid=0, sensor_fault=0; FSM=IDLE.
//  Sync: each bit through 2 flops -> s_vec. Raw input reaches s_vec after 2 edges.
//  FSM states:
//   IDLE     : s_vec == stable_bits. On s_vec != stable_bits -> candidate<=s_vec, cnt<=0, SETTLING.
//   SETTLING : if s_vec != candidate -> candidate<=s_vec, cnt<=0 (restart), stay.
//              else if cnt == STABLE_CYCLES-1 -> COMMIT; else cnt<=cnt+1.
//              if s_vec reverts to stable_bits while settling, still restart on it; commit of an
//              identical value produces no strobe (see COMMIT).
//   COMMIT   : single cycle; stable_bits<=candidate; level<=trailing-ones(candidate);
//              sensor_fault<=(candidate & ~((1<<level_calc)-1)) != 0;
//              level_valid<=1 for this cycle only if candidate != previous stable_bits. -> IDLE.
//  Latency: input edge to level_valid = 2 (sync) + 1 (enter SETTLING) + STABLE_CYCLES + 1 (COMMIT)
//   clock edges, provided input holds steady throughout.
//  Glitches: any change shorter than STABLE_CYCLES clocks restarts count; never committed.
//  Counter width = clog2(STABLE_CYCLES); counter never wraps (compare stops it).
//  Fault rule examples: 0000_0111 -> level 3, fault 0; 0100_0111 -> level 3, fault 1;
//   1111_1111 -> level 8, fault 0; 0000_0000 -> level 0, fault 0; 0000_0010 -> level 0, fault 1.
//  level and sensor_fault change only in COMMIT; hold between commits.
//  Reset mid-SETTLING: pending candidate discarded, no strobe, outputs to reset values.
//  STABLE_CYCLES < 1 is illegal (elaboration-time check).
// STRUCTURE
//  Shared package level_meter_pkg: N_SENSORS, LEVEL_W constants, FSM state enum
//   {IDLE, SETTLING, COMMIT}, function trailing_ones(vec) and function is_thermo(vec) (also used by
//   the threshold stage for setup_input checks).
//  One sub-module: bit_sync_2ff (parameterised width, 2-flop synchroniser, async active-low reset),
//   instantiated once on the whole vector. Debounce counter, FSM and commit logic in this file.
// TESTING  (bench overrides STABLE_CYCLES=16)
//  1 Reset with sensors_input=0x00 held -> outputs all 0, level_valid never pulses over 100 clocks.
//  2 0x00 -> 0xFF held -> level_valid single pulse exactly 2+1+16+1 clocks after change; level=8,
//    stable_bits=0xFF, sensor_fault=0.
//  3 From 0xFF, pulse 0x1B for 10 clocks then back to 0xFF -> no level_valid, outputs unchanged.
//  4 0xFF -> 0x47 held -> level=3, sensor_fault=1; then 0x47 -> 0x07 -> level=3, fault=0, one strobe.
//  5 Input toggles every 8 clocks for 200 clocks, then holds 0x0F -> exactly one strobe, level=4.
//  6 0x07 -> 0x3F, assert reset_n=0 at cnt=10 for 3 clocks -> all outputs 0, no strobe; after release
//    with 0x3F held -> strobe after full latency, level=6.

Source files
------------

// File: rtl/level_meter_pkg.sv
// Shared level-meter definitions: probe/level widths, the debounce FSM state
// type and the probe-vector decoding helpers used by this stage and the threshold stage.
package level_meter_pkg;

    localparam int N_SENSORS = 8;
    localparam int LEVEL_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        COMMIT
    } state_e;

    // Number of consecutive wetted probes counted upward from bit 0.
    function automatic logic [LEVEL_W-1:0] trailing_ones(input logic [N_SENSORS-1:0] vec);
        logic [LEVEL_W-1:0] n;
        logic               run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (run && vec[i]) begin
                n = n + LEVEL_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    // A thermometer code is 2**k-1, so adding one clears every set bit.
    function automatic logic is_thermo(input logic [N_SENSORS-1:0] vec);
        logic [N_SENSORS:0] v;
        v = {1'b0, vec};
        return (v & (v + (N_SENSORS + 1)'(1))) == '0;
    endfunction

endpackage

// File: rtl/sensor_level_filter_if.sv
// Probe inputs and settled-level outputs of the level filter, bundled for
// the filter (master) and its threshold/display consumer (slave).
interface sensor_level_filter_if;

    logic [level_meter_pkg::N_SENSORS-1:0] sensors_input;
    logic [level_meter_pkg::N_SENSORS-1:0] stable_bits;
    logic [level_meter_pkg::LEVEL_W-1:0]   level;
    logic                                  level_valid;
    logic                                  sensor_fault;

    modport master (
        input  sensors_input,
        output stable_bits,
        output level,
        output level_valid,
        output sensor_fault
    );

    modport slave (
        output sensors_input,
        input  stable_bits,
        input  level,
        input  level_valid,
        input  sensor_fault
    );

endinterface

// File: rtl/sensor_level_filter_bit_sync.sv
// Two-flop synchroniser for a vector of independent asynchronous lines.
module bit_sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d_in;
            sync2_q <= sync1_q;
        end
    end

    assign d_out = sync2_q;

endmodule

// File: rtl/sensor_level_filter.sv
// Liquid-level probe conditioner: synchronise, debounce the whole probe vector,
// then publish the settled level, a change strobe and a non-thermometer fault flag.
module sensor_level_filter
    import level_meter_pkg::*;
#(
    parameter int STABLE_CYCLES = 500_000
) (
    input  logic                  clk_100MHz,
    input  logic                  reset_n,
    sensor_level_filter_if.master bus
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
        $error("sensor_level_filter: STABLE_CYCLES must be at least 1");
    end
    if ((2 ** LEVEL_W) <= N_SENSORS) begin : g_bad_level_w
        $error("sensor_level_filter: LEVEL_W too narrow for N_SENSORS");
    end

    logic [N_SENSORS-1:0] s_vec;

    state_e               state_q,        state_d;
    logic [N_SENSORS-1:0] candidate_q,    candidate_d;
    logic [CNT_W-1:0]     cnt_q,          cnt_d;
    logic [N_SENSORS-1:0] stable_bits_q,  stable_bits_d;
    logic [LEVEL_W-1:0]   level_q,        level_d;
    logic                 level_valid_q,  level_valid_d;
    logic                 sensor_fault_q, sensor_fault_d;

    bit_sync_2ff #(
        .WIDTH (N_SENSORS)
    ) u_sync (
        .clk   (clk_100MHz),
        .rst_n (reset_n),
        .d_in  (bus.sensors_input),
        .d_out (s_vec)
    );

    // Any difference from the candidate restarts the count, so only a vector held
    // for STABLE_CYCLES consecutive clocks reaches COMMIT.
    always_comb begin
        state_d        = state_q;
        candidate_d    = candidate_q;
        cnt_d          = cnt_q;
        stable_bits_d  = stable_bits_q;
        level_d        = level_q;
        sensor_fault_d = sensor_fault_q;
        level_valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_vec != stable_bits_q) begin
                    candidate_d = s_vec;
                    cnt_d       = '0;
                    state_d     = SETTLING;
                end
            end
            SETTLING: begin
                if (s_vec != candidate_q) begin
                    candidate_d = s_vec;
                    cnt_d       = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMMIT: begin
                stable_bits_d  = candidate_q;
                level_d        = trailing_ones(candidate_q);
                sensor_fault_d = !is_thermo(candidate_q);
                level_valid_d  = (candidate_q != stable_bits_q);
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            candidate_q    <= '0;
            cnt_q          <= '0;
            stable_bits_q  <= '0;
            level_q        <= '0;
            level_valid_q  <= 1'b0;
            sensor_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            candidate_q    <= candidate_d;
            cnt_q          <= cnt_d;
            stable_bits_q  <= stable_bits_d;
            level_q        <= level_d;
            level_valid_q  <= level_valid_d;
            sensor_fault_q <= sensor_fault_d;
        end
    end

    assign bus.stable_bits  = stable_bits_q;
    assign bus.level        = level_q;
    assign bus.level_valid  = level_valid_q;
    assign bus.sensor_fault = sensor_fault_q;

endmodule
